// File: rtl/parking_pkg.sv
// ============================================================================
// Module   : parking_pkg
// Purpose  : Shared types and default sizing for the parking gate arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package parking_pkg;

  localparam int CAPACITY_DEF = 10;
  localparam int CNT_W_DEF    = 4;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    OPENING    = 3'd1,
    WAIT_PASS  = 3'd2,
    WAIT_CLEAR = 3'd3,
    CLOSING    = 3'd4
  } gate_state_t;

  typedef enum logic {
    DIR_IN  = 1'b0,
    DIR_OUT = 1'b1
  } dir_t;

  function automatic logic gate_is_open(input gate_state_t s);
    return (s == OPENING) || (s == WAIT_PASS) || (s == WAIT_CLEAR);
  endfunction

endpackage

`default_nettype wire

// File: rtl/gate_timer.sv
// ============================================================================
// Module   : gate_timer
// Purpose  : Loadable down-counter; done is high while the count sits at zero.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module gate_timer #(
  parameter int TMR_W = 8
) (
  input  logic             clk_2,
  input  logic             reset_n,
  input  logic             load,
  input  logic [TMR_W-1:0] load_value,
  output logic             done
);

  logic [TMR_W-1:0] count;

  always_ff @(posedge clk_2 or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (count != '0) begin
      count <= count - TMR_W'(1);
    end
  end

  assign done = (count == '0);

endmodule

`default_nettype wire

// File: rtl/parking_gate_arbiter.sv
// ============================================================================
// Module   : parking_gate_arbiter
// Purpose  : Single-lane gate sequencer/arbiter with registered occupancy.
//            Optional WAIT_PASS abort enabled by PARKING_GATE_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module parking_gate_arbiter
  import parking_pkg::*;
#(
  parameter int CAPACITY       = CAPACITY_DEF,
  parameter int CNT_W          = CNT_W_DEF,
  parameter int OPEN_CYCLES    = 4,
  parameter int CLOSE_CYCLES   = 4,
  parameter int TIMEOUT_CYCLES = 200,
  parameter int TMR_W          = 8
) (
  input  logic             clk_2,
  input  logic             reset_n,
  input  logic             req_in,
  input  logic             req_out,
  input  logic             car_sensor,
  output logic             grant_in,
  output logic             grant_out,
  output logic             gate_open,
  output logic             busy,
  output logic [CNT_W-1:0] num_cars,
  output logic             full,
  output logic             empty,
  output logic             timeout_evt
);

  localparam logic [CNT_W-1:0] CAP_C    = CNT_W'(CAPACITY);
  // Timers load N-1 so that the state is held for exactly N clocks.
  localparam logic [TMR_W-1:0] OPEN_LD  = TMR_W'(OPEN_CYCLES - 1);
  localparam logic [TMR_W-1:0] CLOSE_LD = TMR_W'(CLOSE_CYCLES - 1);
  localparam logic [TMR_W-1:0] TOUT_LD  = TMR_W'(TIMEOUT_CYCLES - 1);

  gate_state_t      state_q, state_d;
  dir_t             dir_q, dir_d;
  dir_t             last_dir_q, last_dir_d;
  logic [CNT_W-1:0] cars_d;
  logic             tmr_load;
  logic [TMR_W-1:0] tmr_val;
  logic             tmr_done;
  logic             elig_in, elig_out;

  assign elig_in  = req_in  && (num_cars < CAP_C);
  assign elig_out = req_out && (num_cars != '0);

  gate_timer #(
    .TMR_W (TMR_W)
  ) u_timer (
    .clk_2      (clk_2),
    .reset_n    (reset_n),
    .load       (tmr_load),
    .load_value (tmr_val),
    .done       (tmr_done)
  );

`ifdef PARKING_GATE_TIMEOUT_EN
  logic tout_d;
`endif

  always_comb begin
    state_d    = state_q;
    dir_d      = dir_q;
    last_dir_d = last_dir_q;
    cars_d     = num_cars;
    tmr_load   = 1'b0;
    tmr_val    = '0;
`ifdef PARKING_GATE_TIMEOUT_EN
    tout_d     = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        // On a tie the direction not served last time wins.
        if (elig_in && (!elig_out || (last_dir_q == DIR_OUT))) begin
          dir_d    = DIR_IN;
          state_d  = OPENING;
          tmr_load = 1'b1;
          tmr_val  = OPEN_LD;
        end else if (elig_out) begin
          dir_d    = DIR_OUT;
          state_d  = OPENING;
          tmr_load = 1'b1;
          tmr_val  = OPEN_LD;
        end
      end
      OPENING: begin
        if (tmr_done) begin
          state_d  = WAIT_PASS;
          tmr_load = 1'b1;
          tmr_val  = TOUT_LD;
        end
      end
      WAIT_PASS: begin
        if (car_sensor) begin
          state_d = WAIT_CLEAR;
        end
`ifdef PARKING_GATE_TIMEOUT_EN
        else if (tmr_done) begin
          state_d  = CLOSING;
          tout_d   = 1'b1;
          tmr_load = 1'b1;
          tmr_val  = CLOSE_LD;
        end
`endif
      end
      WAIT_CLEAR: begin
        if (!car_sensor) begin
          state_d    = CLOSING;
          last_dir_d = dir_q;
          cars_d     = (dir_q == DIR_IN) ? num_cars + CNT_W'(1)
                                         : num_cars - CNT_W'(1);
          tmr_load   = 1'b1;
          tmr_val    = CLOSE_LD;
        end
      end
      CLOSING: begin
        if (tmr_done) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_2 or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      dir_q      <= DIR_IN;
      last_dir_q <= DIR_OUT;
      num_cars   <= '0;
      full       <= 1'b0;
      empty      <= 1'b1;
      grant_in   <= 1'b0;
      grant_out  <= 1'b0;
      gate_open  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state_q    <= state_d;
      dir_q      <= dir_d;
      last_dir_q <= last_dir_d;
      num_cars   <= cars_d;
      full       <= (cars_d == CAP_C);
      empty      <= (cars_d == '0);
      grant_in   <= (state_d != IDLE) && (dir_d == DIR_IN);
      grant_out  <= (state_d != IDLE) && (dir_d == DIR_OUT);
      gate_open  <= gate_is_open(state_d);
      busy       <= (state_d != IDLE);
    end
  end

`ifdef PARKING_GATE_TIMEOUT_EN
  always_ff @(posedge clk_2 or negedge reset_n) begin
    if (!reset_n) begin
      timeout_evt <= 1'b0;
    end else begin
      timeout_evt <= tout_d;
    end
  end
`else
  assign timeout_evt = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_parking_gate_arbiter.sv
// ============================================================================
// Module   : tb_parking_gate_arbiter
// Purpose  : Scoreboard bench for parking_gate_arbiter (grant and count).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_parking_gate_arbiter;

  localparam int CAP   = 10;
  localparam int CW    = 4;
  localparam int OPEN  = 4;
  localparam int CLOSE = 4;
  localparam int TOUT  = 20;

  logic          clk_2 = 1'b0;
  logic          reset_n;
  logic          req_in, req_out, car_sensor;
  logic          grant_in, grant_out, gate_open, busy, full, empty, timeout_evt;
  logic [CW-1:0] num_cars;

  parking_gate_arbiter #(
    .CAPACITY       (CAP),
    .CNT_W          (CW),
    .OPEN_CYCLES    (OPEN),
    .CLOSE_CYCLES   (CLOSE),
    .TIMEOUT_CYCLES (TOUT),
    .TMR_W          (8)
  ) dut (
    .clk_2       (clk_2),
    .reset_n     (reset_n),
    .req_in      (req_in),
    .req_out     (req_out),
    .car_sensor  (car_sensor),
    .grant_in    (grant_in),
    .grant_out   (grant_out),
    .gate_open   (gate_open),
    .busy        (busy),
    .num_cars    (num_cars),
    .full        (full),
    .empty       (empty),
    .timeout_evt (timeout_evt)
  );

  always #5 clk_2 = ~clk_2;

  typedef struct {
    bit gin;
    bit gout;
    int cars;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   m_cars   = 0;
  bit   m_last_out = 1'b1;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Monitor: grant direction on busy rise, count/full/empty on count change.
  logic          prev_busy = 1'b0;
  logic [CW-1:0] prev_cars = '0;
  always @(negedge clk_2) begin
    exp_t e;
    if (!reset_n) begin
      prev_busy = 1'b0;
      prev_cars = '0;
    end else begin
      if (busy && !prev_busy && sb.size() > 0) begin
        check("sb_grant_in", int'(grant_in), int'(sb[0].gin));
        check("sb_grant_out", int'(grant_out), int'(sb[0].gout));
      end
      if (num_cars != prev_cars) begin
        if (sb.size() == 0) begin
          check("cnt_unexpected", int'(num_cars), int'(prev_cars));
        end else begin
          e = sb.pop_front();
          check("sb_num_cars", int'(num_cars), e.cars);
          check("sb_full", int'(full), int'(e.cars == CAP));
          check("sb_empty", int'(empty), int'(e.cars == 0));
        end
      end
      prev_busy = busy;
      prev_cars = num_cars;
    end
  end

  task automatic run_cross(input logic rin, input logic rout, input int hi_clks);
    exp_t e;
    bit   ein, eout, take_in;
    int   k;
    ein     = rin && (m_cars < CAP);
    eout    = rout && (m_cars > 0);
    take_in = ein && (!eout || m_last_out);
    e.gin   = take_in;
    e.gout  = !take_in;
    e.cars  = take_in ? m_cars + 1 : m_cars - 1;
    sb.push_back(e);
    @(negedge clk_2);
    req_in  = rin;
    req_out = rout;
    @(negedge clk_2);
    check("grant_latency_busy", int'(busy), 1);
    check("grant_gate_open", int'(gate_open), 1);
    req_in  = 1'b0;
    req_out = 1'b0;
    repeat (OPEN) @(negedge clk_2);
    car_sensor = 1'b1;
    repeat (hi_clks) @(negedge clk_2);
    car_sensor = 1'b0;
    k = 0;
    while (busy && k < 40) begin
      @(negedge clk_2);
      k++;
    end
    check("close_latency", k, CLOSE + 1);
    m_cars     = e.cars;
    m_last_out = !take_in;
  endtask

  task automatic hold_no_grant(input string tag, input logic rin, input logic rout);
    int seen;
    seen = 0;
    @(negedge clk_2);
    req_in  = rin;
    req_out = rout;
    repeat (6) begin
      @(negedge clk_2);
      if (busy || grant_in || grant_out) seen++;
    end
    req_in  = 1'b0;
    req_out = 1'b0;
    check(tag, seen, 0);
  endtask

  initial begin
    int k;
    int tev;
    reset_n    = 1'b0;
    req_in     = 1'b0;
    req_out    = 1'b0;
    car_sensor = 1'b0;
    repeat (2) @(negedge clk_2);
    check("rst_num_cars", int'(num_cars), 0);
    check("rst_empty", int'(empty), 1);
    check("rst_full", int'(full), 0);
    check("rst_busy_gate", int'({busy, gate_open, grant_in, grant_out, timeout_evt}), 0);
    #2 reset_n = 1'b1;

    // Empty lot: exit request is never granted
    hold_no_grant("empty_no_grant", 1'b0, 1'b1);

    // Lone entry, sensor high 3 clocks
    run_cross(1'b1, 1'b0, 3);
    check("lone_entry_count", int'(num_cars), 1);

    // Reach 5 with exit as the last served direction, then tie twice
    repeat (5) run_cross(1'b1, 1'b0, 1);
    run_cross(1'b0, 1'b1, 1);
    run_cross(1'b1, 1'b1, 1);
    check("tie1_count", int'(num_cars), 6);
    run_cross(1'b1, 1'b1, 1);
    check("tie2_count", int'(num_cars), 5);

    // Fill, then refuse entry and serve exit
    while (m_cars < CAP) run_cross(1'b1, 1'b0, 1);
    check("full_flag", int'(full), 1);
    hold_no_grant("full_entry_refused", 1'b1, 1'b0);
    run_cross(1'b1, 1'b1, 2);
    check("full_exit_count", int'(num_cars), 9);

    // Sensor never rises after an entry grant
    @(negedge clk_2);
    req_in = 1'b1;
    @(negedge clk_2);
    check("tout_grant_in", int'(grant_in), 1);
    req_in = 1'b0;
    repeat (OPEN) @(negedge clk_2);
`ifdef PARKING_GATE_TIMEOUT_EN
    k = 0;
    while (!timeout_evt && k < TOUT + 20) begin
      @(negedge clk_2);
      k++;
    end
    check("tout_latency", k, TOUT);
    check("tout_gate_closed", int'(gate_open), 0);
    @(negedge clk_2);
    check("tout_pulse_width", int'(timeout_evt), 0);
    k = 0;
    while (busy && k < 40) begin
      @(negedge clk_2);
      k++;
    end
    check("tout_back_idle", int'(busy), 0);
    check("tout_count_kept", int'(num_cars), 9);
`else
    tev = 0;
    repeat (TOUT + 40) begin
      @(negedge clk_2);
      if (timeout_evt) tev++;
    end
    check("no_tout_evt", tev, 0);
    check("no_tout_gate_open", int'(gate_open), 1);
    check("no_tout_busy", int'(busy), 1);
    begin
      exp_t e;
      e.gin  = 1'b1;
      e.gout = 1'b0;
      e.cars = 10;
      sb.push_back(e);
    end
    car_sensor = 1'b1;
    @(negedge clk_2);
    car_sensor = 1'b0;
    k = 0;
    while (busy && k < 40) begin
      @(negedge clk_2);
      k++;
    end
    check("no_tout_close", k, CLOSE + 1);
    m_cars     = 10;
    m_last_out = 1'b0;
`endif

    // Drain to 3, then reset while a car is in the lane
    while (m_cars > 3) run_cross(1'b0, 1'b1, 1);
    @(negedge clk_2);
    req_in = 1'b1;
    @(negedge clk_2);
    req_in = 1'b0;
    repeat (OPEN) @(negedge clk_2);
    car_sensor = 1'b1;
    @(negedge clk_2);
    check("pre_rst_count", int'(num_cars), 3);
    reset_n = 1'b0;
    #1;
    check("midrst_num_cars", int'(num_cars), 0);
    check("midrst_empty", int'(empty), 1);
    check("midrst_outputs", int'({busy, gate_open, grant_in, grant_out, full}), 0);
    repeat (2) @(negedge clk_2);
    car_sensor = 1'b0;
    #2 reset_n = 1'b1;
    m_cars     = 0;
    m_last_out = 1'b1;
    run_cross(1'b1, 1'b1, 1);
    check("post_rst_count", int'(num_cars), 1);
    check("sb_drained", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
